// File: rtl/cdr_phase_controller.sv
// ---------------------------------------------------------------------------
// cdr_phase_controller
//
// Picks the data-sampling phase for an oversampling CDR. Edge reports
// (edge_valid/edge_phase) are voted on; once a phase index has been reported
// FILTER_DEPTH times in a row it becomes the adopted edge reference edge_ref.
// The sampling phase sits half a UI away from that edge:
//   phase_sel = (edge_ref + N_PHASE/2) mod N_PHASE.
// Adjacent edge drift is tracked in place; a non-adjacent edge or a long
// silence throws the loop back into acquisition.
//
// States: IDLE -> ACQUIRE -> TRACK -> LOCKED.
//
// Ports:
//   ref_clk       in   sole clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   enable        in   run request; low forces IDLE (phase_sel retained)
//   edge_valid    in   transition detected this cycle
//   edge_phase    in   [SW] phase index of the transition
//   phase_sel     out  [SW] sampling phase for the data mux
//   locked        out  lock status
//   phase_update  out  one-cycle pulse when a new edge reference is adopted
//   slip_err      out  one-cycle pulse when lock is lost
//   stats_clr     in   (CDR_PHASE_CTRL_STATS_EN only) clear slip_count
//   slip_count    out  [8] (CDR_PHASE_CTRL_STATS_EN only) saturating count
//                      of slip_err pulses
//
// Optional feature macro: CDR_PHASE_CTRL_STATS_EN
// ---------------------------------------------------------------------------
module cdr_phase_controller #(
  parameter int N_PHASE      = 5,
  parameter int FILTER_DEPTH = 4,
  parameter int LOCK_COUNT   = 16,
  parameter int LOSS_COUNT   = 64,
  localparam int SW          = $clog2(N_PHASE)
) (
  input  logic          ref_clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          edge_valid,
  input  logic [SW-1:0] edge_phase,
`ifdef CDR_PHASE_CTRL_STATS_EN
  input  logic          stats_clr,
  output logic [7:0]    slip_count,
`endif
  output logic [SW-1:0] phase_sel,
  output logic          locked,
  output logic          phase_update,
  output logic          slip_err
);

  localparam int VW = $clog2(FILTER_DEPTH + 1);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam int TW = $clog2(LOSS_COUNT + 1);

  localparam logic [SW:0]   NP       = (SW+1)'(N_PHASE);
  localparam logic [SW:0]   HALF     = (SW+1)'(N_PHASE / 2);
  localparam logic [SW:0]   STEP_UP  = (SW+1)'(1);
  localparam logic [SW:0]   STEP_DN  = (SW+1)'(N_PHASE - 1);
  localparam logic [SW-1:0] PSEL_RST = SW'(N_PHASE / 2);
  localparam logic [VW-1:0] FD       = VW'(FILTER_DEPTH);
  localparam logic [LW-1:0] LC       = LW'(LOCK_COUNT);
  localparam logic [TW-1:0] LOSS     = TW'(LOSS_COUNT);
  localparam logic [TW-1:0] LOSS_M1  = TW'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} state_t;

  // (a + b) mod N_PHASE for a, b < N_PHASE: one conditional subtract is
  // enough, so the result can never reach N_PHASE.
  function automatic logic [SW-1:0] phase_add(input logic [SW-1:0] a,
                                              input logic [SW:0]   b);
    logic [SW:0] s;
    s = {1'b0, a} + b;
    if (s >= NP) s = s - NP;
    return s[SW-1:0];
  endfunction

  state_t        state, state_n;
  logic [SW-1:0] edge_ref, edge_ref_n;
  logic [SW-1:0] phase_sel_n;
  logic [SW-1:0] candidate, candidate_n;
  logic [VW-1:0] vote_cnt, vote_n, vote_inc;
  logic [LW-1:0] stable_cnt, stable_n, stable_inc;
  logic [TW-1:0] silence_cnt, silence_n;
  logic          locked_n, phase_update_n, slip_err_n;
  logic          ev, vote_full, is_adj, sil_hit;

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      edge_ref     <= '0;
      phase_sel    <= PSEL_RST;
      candidate    <= '0;
      vote_cnt     <= '0;
      stable_cnt   <= '0;
      silence_cnt  <= '0;
      locked       <= 1'b0;
      phase_update <= 1'b0;
      slip_err     <= 1'b0;
    end else begin
      state        <= state_n;
      edge_ref     <= edge_ref_n;
      phase_sel    <= phase_sel_n;
      candidate    <= candidate_n;
      vote_cnt     <= vote_n;
      stable_cnt   <= stable_n;
      silence_cnt  <= silence_n;
      locked       <= locked_n;
      phase_update <= phase_update_n;
      slip_err     <= slip_err_n;
    end
  end

  always_comb begin
    state_n        = state;
    edge_ref_n     = edge_ref;
    phase_sel_n    = phase_sel;
    candidate_n    = candidate;
    vote_n         = vote_cnt;
    stable_n       = stable_cnt;
    silence_n      = silence_cnt;
    locked_n       = locked;
    phase_update_n = 1'b0;
    slip_err_n     = 1'b0;

    // An out-of-range index cannot be a real transition; it is ignored and
    // the cycle counts as silent, so edge_ref can never leave 0..N_PHASE-1.
    ev = edge_valid && ({1'b0, edge_phase} < NP);

    vote_inc   = (edge_phase == candidate)
                 ? ((vote_cnt == FD) ? vote_cnt : vote_cnt + VW'(1))
                 : VW'(1);
    vote_full  = (vote_inc == FD);
    stable_inc = (stable_cnt == LC) ? stable_cnt : stable_cnt + LW'(1);
    is_adj     = (edge_phase == phase_add(edge_ref, STEP_UP)) ||
                 (edge_phase == phase_add(edge_ref, STEP_DN));
    // Only a silent cycle can time out, so timeout and edge handling never
    // compete within one cycle.
    sil_hit    = !ev && (silence_cnt == LOSS_M1);

    if (ev)                        silence_n = '0;
    else if (silence_cnt != LOSS)  silence_n = silence_cnt + TW'(1);

    if (!enable) begin
      state_n   = IDLE;
      locked_n  = 1'b0;
      vote_n    = '0;
      stable_n  = '0;
      silence_n = '0;
    end else begin
      case (state)
        IDLE: begin
          // Silence is only measured while running.
          state_n   = ACQUIRE;
          vote_n    = '0;
          silence_n = '0;
        end

        ACQUIRE: begin
          if (ev) begin
            candidate_n = edge_phase;
            if (vote_full) begin
              edge_ref_n     = edge_phase;
              phase_sel_n    = phase_add(edge_phase, HALF);
              phase_update_n = 1'b1;
              vote_n         = '0;
              stable_n       = '0;
              state_n        = TRACK;
            end else begin
              vote_n = vote_inc;
            end
          end
        end

        TRACK, LOCKED: begin
          if (sil_hit) begin
            state_n    = ACQUIRE;
            locked_n   = 1'b0;
            slip_err_n = (state == LOCKED);
            vote_n     = '0;
            stable_n   = '0;
          end else if (ev) begin
            if (edge_phase == edge_ref) begin
              // A confirming edge also cancels any half-built drift vote.
              vote_n   = '0;
              stable_n = stable_inc;
              if (state == TRACK && stable_inc == LC) begin
                state_n  = LOCKED;
                locked_n = 1'b1;
              end
            end else if (is_adj) begin
              candidate_n = edge_phase;
              if (vote_full) begin
                edge_ref_n     = edge_phase;
                phase_sel_n    = phase_add(edge_phase, HALF);
                phase_update_n = 1'b1;
                vote_n         = '0;
                // LOCKED keeps its confidence across a one-step drift.
                if (state == TRACK) stable_n = '0;
              end else begin
                vote_n = vote_inc;
              end
            end else begin
              // The reporting edge is the first vote of the new acquisition.
              state_n     = ACQUIRE;
              candidate_n = edge_phase;
              vote_n      = VW'(1);
              stable_n    = '0;
              locked_n    = 1'b0;
              slip_err_n  = (state == LOCKED);
            end
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

`ifdef CDR_PHASE_CTRL_STATS_EN
  // Counts registered slip_err pulses; a clear on the same cycle wins.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n)                              slip_count <= '0;
    else if (stats_clr)                      slip_count <= '0;
    else if (slip_err && slip_count != 8'hFF) slip_count <= slip_count + 8'd1;
  end
`endif

endmodule
